// File: rtl/e203_tcm_sram_banked.sv
// rtl/e203_tcm_sram_banked.sv - word-interleaved banked TCM SRAM with byte writes and LS/SD/WAKE power control
// Optional second read register stage (2-cycle read latency): define E203_TCM_RAM_OUTREG_EN.
module e203_tcm_sram_banked #(
    parameter int DW       = 32,
    parameter int AW       = 14,
    parameter int BANKS    = 2,
    parameter int WAKE_CYC = 4
) (
    input  logic            clk_tcm_ram,
    input  logic            rst_tcm,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW/8-1:0] cmd_wem,
    input  logic [DW-1:0]   cmd_din,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    input  logic            pwr_ls_req,
    input  logic            pwr_sd_req,
    output logic [1:0]      pwr_state
);
    localparam int LOG2B = (BANKS > 1) ? $clog2(BANKS) : 0;
    localparam int SELW  = (BANKS > 1) ? LOG2B : 1;
    localparam int RW    = AW - LOG2B;
    localparam int ROWS  = 1 << RW;
    localparam int NB    = DW / 8;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_LS     = 2'd1,
        ST_SD     = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      wake_cnt;
    logic            ls_exit;
    logic            accept;
    logic            rd_accept;
    logic            rd_pending;
    logic [SELW-1:0] bank_sel;
    logic [RW-1:0]   row;
    logic [BANKS-1:0] bank_cs;
    logic [DW-1:0]   bank_dout [BANKS];
    logic            s1_valid;
    logic [DW-1:0]   s1_data;

    always_comb begin
        bank_sel = '0;
        if (BANKS > 1) bank_sel = cmd_addr[SELW-1:0];
    end

    assign row       = RW'(cmd_addr >> LOG2B);
    assign accept    = cmd_valid && cmd_ready;
    assign rd_accept = accept && !cmd_we;
    assign bank_cs   = accept ? (BANKS'(1) << bank_sel) : '0;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DW-1:0] ram [ROWS];

        always_ff @(posedge clk_tcm_ram) begin
            if (bank_cs[b] && cmd_we) begin
                for (int i = 0; i < NB; i++) begin
                    if (cmd_wem[i]) ram[row][i*8 +: 8] <= cmd_din[i*8 +: 8];
                end
            end
        end

        assign bank_dout[b] = ram[row];
    end

    always_ff @(posedge clk_tcm_ram or posedge rst_tcm) begin
        if (rst_tcm) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) s1_data <= bank_dout[bank_sel];
        end
    end

`ifdef E203_TCM_RAM_OUTREG_EN
    logic          s2_valid;
    logic [DW-1:0] s2_data;

    always_ff @(posedge clk_tcm_ram or posedge rst_tcm) begin
        if (rst_tcm) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s1_data;
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_rdata  = s2_data;
    assign rd_pending = s1_valid || s2_valid;
`else
    assign rsp_valid  = s1_valid;
    assign rsp_rdata  = s1_data;
    assign rd_pending = s1_valid;
`endif

    always_ff @(posedge clk_tcm_ram or posedge rst_tcm) begin
        if (rst_tcm) state <= ST_ACTIVE;
        else         state <= state_nxt;
    end

    // LS entry is skipped in the first ACTIVE cycle after an LS exit so the waking command gets in.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ACTIVE: begin
                if (pwr_sd_req && !rd_pending)
                    state_nxt = ST_SD;
                else if (!pwr_sd_req && pwr_ls_req && !ls_exit && !rd_pending)
                    state_nxt = ST_LS;
            end
            ST_LS: begin
                if (pwr_sd_req)                     state_nxt = ST_SD;
                else if (!pwr_ls_req || cmd_valid)  state_nxt = ST_ACTIVE;
            end
            ST_SD: begin
                if (!pwr_sd_req) state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (pwr_sd_req)                          state_nxt = ST_SD;
                else if (wake_cnt == 4'(WAKE_CYC - 1))   state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_ACTIVE;
        endcase
    end

    // An outstanding power request stops new commands so pending reads can drain.
    always_comb begin
        pwr_state = state;
        cmd_ready = (state == ST_ACTIVE) && !pwr_sd_req && !(pwr_ls_req && !ls_exit);
    end

    always_ff @(posedge clk_tcm_ram or posedge rst_tcm) begin
        if (rst_tcm) begin
            wake_cnt <= 4'd0;
            ls_exit  <= 1'b0;
        end else begin
            wake_cnt <= (state == ST_WAKE && state_nxt == ST_WAKE) ? wake_cnt + 4'd1 : 4'd0;
            ls_exit  <= (state == ST_LS && state_nxt == ST_ACTIVE);
        end
    end
endmodule

// File: tb/tb_e203_tcm_sram_banked.sv
// tb/tb_e203_tcm_sram_banked.sv - self-checking bench for e203_tcm_sram_banked
module tb_e203_tcm_sram_banked;
    localparam int DW = 32;
    localparam int AW = 14;
    localparam int BANKS = 2;
    localparam int WAKE_CYC = 4;
`ifdef E203_TCM_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [3:0]    cmd_wem = '0;
    logic [DW-1:0] cmd_din = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          pwr_ls_req = 1'b0;
    logic          pwr_sd_req = 1'b0;
    logic [1:0]    pwr_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [int];
    bit          pipe_v [$];
    logic [31:0] pipe_d [$];
    logic [31:0] last_d = '0;

    e203_tcm_sram_banked #(.DW(DW), .AW(AW), .BANKS(BANKS), .WAKE_CYC(WAKE_CYC)) dut (
        .clk_tcm_ram(clk), .rst_tcm(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wem(cmd_wem), .cmd_din(cmd_din),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .pwr_ls_req(pwr_ls_req), .pwr_sd_req(pwr_sd_req), .pwr_state(pwr_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] wem);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++)
            if (wem[i]) r[i*8 +: 8] = din[i*8 +: 8];
        return r;
    endfunction

    // One clock: present a command, apply the model, then check the response slot due now.
    task automatic cyc(input bit v, input bit we, input int addr, input logic [3:0] wem,
                       input logic [31:0] din, input bit acc);
        bit          rv;
        logic [31:0] rd;
        logic [31:0] exp_cs;
        cmd_valid = v; cmd_we = we; cmd_addr = AW'(addr); cmd_wem = wem; cmd_din = din;
        #1;
        if (v) chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, acc});
        exp_cs = (v && acc) ? (32'd1 << (addr % BANKS)) : 32'd0;
        chk("bank_cs", 32'(dut.bank_cs), exp_cs);
        rv = v && acc && !we;
        rd = rv ? mdl[addr] : 32'd0;
        if (v && acc && we) mdl[addr] = merge(mdl.exists(addr) ? mdl[addr] : 32'd0, din, wem);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        pipe_v.push_back(rv);
        pipe_d.push_back(rd);
        if (pipe_v.size() >= LAT) begin
            bit          ev = pipe_v.pop_front();
            logic [31:0] ed = pipe_d.pop_front();
            if (ev) last_d = ed;
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
            chk("rsp_rdata", rsp_rdata, last_d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 4'h0, 32'd0, 1'b0);
    endtask

    initial begin
        #3;
        chk("reset pwr_state", 32'(pwr_state), 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("ready after reset", {31'd0, cmd_ready}, 32'd1);

        // basic write/read and byte-masked merge
        cyc(1, 1, 5, 4'hF, 32'hDEADBEEF, 1);
        cyc(1, 0, 5, 4'h0, 32'd0, 1);
        chk("read 0x5 data", rsp_rdata, 32'hDEADBEEF);
        cyc(1, 1, 2, 4'hF, 32'h11223344, 1);
        cyc(1, 1, 2, 4'h2, 32'h0000AA00, 1);
        cyc(1, 0, 2, 4'h0, 32'd0, 1);
        chk("masked merge", rsp_rdata, 32'h1122AA44);

        // back-to-back reads across banks
        cyc(1, 1, 0, 4'hF, 32'h0000000A, 1);
        cyc(1, 1, 1, 4'hF, 32'h0000000B, 1);
        cyc(1, 0, 0, 4'h0, 32'd0, 1);
        cyc(1, 0, 1, 4'h0, 32'd0, 1);
        idle(2);

        // randomized traffic over a small window
        for (int a = 0; a < 16; a++) cyc(1, 1, a, 4'hF, $urandom, 1);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                4'($urandom), $urandom, 1);
        idle(3);

        // light sleep with data retention and command wake-up
        cyc(1, 1, 7, 4'hF, 32'hCAFEF00D, 1);
        pwr_ls_req = 1'b1;
        #1;
        chk("ready with ls_req", {31'd0, cmd_ready}, 32'd0);
        idle(1);
        chk("state LS", 32'(pwr_state), 32'd1);
        chk("ready in LS", {31'd0, cmd_ready}, 32'd0);
        cyc(1, 0, 7, 4'h0, 32'd0, 0);
        chk("LS wake to ACTIVE", 32'(pwr_state), 32'd0);
        cyc(1, 0, 7, 4'h0, 32'd0, 1);
        chk("data after LS", rsp_rdata, 32'hCAFEF00D);
        pwr_ls_req = 1'b0;
        idle(3);
        chk("back to ACTIVE", 32'(pwr_state), 32'd0);

        // shutdown pulse, then wake sequence, including a re-shutdown during WAKE
        for (int pass = 0; pass < 2; pass++) begin
            pwr_sd_req = 1'b1;
            idle(1);
            chk("state SD", 32'(pwr_state), 32'd2);
            pwr_sd_req = 1'b0;
            if (pass == 0) begin
                idle(2);
                chk("early WAKE", 32'(pwr_state), 32'd3);
                pwr_sd_req = 1'b1;
                idle(1);
                chk("WAKE back to SD", 32'(pwr_state), 32'd2);
                pwr_sd_req = 1'b0;
            end
            for (int w = 0; w < WAKE_CYC; w++) begin
                idle(1);
                chk("WAKE cycle", 32'(pwr_state), 32'd3);
            end
            idle(1);
            chk("ACTIVE after wake", 32'(pwr_state), 32'd0);
            chk("ready after wake", {31'd0, cmd_ready}, 32'd1);
        end
        mdl.delete();

        // reset while a read response is in flight; memory survives reset
        cyc(1, 1, 5, 4'hF, 32'h5A5A0FF0, 1);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = AW'(5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst pwr_state", 32'(pwr_state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pipe_v.delete();
        pipe_d.delete();
        last_d = 32'd0;
        #1;
        chk("ready after mid reset", {31'd0, cmd_ready}, 32'd1);
        cyc(1, 0, 5, 4'h0, 32'd0, 1);
        idle(LAT);
        chk("data after reset", rsp_rdata, 32'h5A5A0FF0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/e203_tcm_sram_banked.md
E203_TCM_SRAM_BANKED -- requirements
Module: e203_tcm_sram_banked

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits (32 or 64).
REQ-002 SHALL have parameter AW, default 14, meaning word address width across all banks.
REQ-003 SHALL have parameter BANKS, default 2, meaning interleaved bank count (1, 2 or 4).
REQ-004 SHALL have parameter WAKE_CYC, default 4, meaning wake-up cycles after shutdown exit (1..15).
REQ-005 SHALL have port clk_tcm_ram  input  1  clock.
REQ-006 SHALL have port rst_tcm  input  1  reset; one clock, asynchronous, active-high.
REQ-007 SHALL have ports cmd_valid input 1, cmd_ready output 1: request handshake.
REQ-008 SHALL have ports cmd_we input 1, cmd_addr input AW, cmd_wem input DW/8, cmd_din input DW: write flag, word address, byte mask, write data.
REQ-009 SHALL have ports rsp_valid output 1, rsp_rdata output DW: read response.
REQ-010 SHALL have ports pwr_ls_req input 1, pwr_sd_req input 1: light-sleep and shutdown requests.
REQ-011 SHALL have port pwr_state output 2: 0 ACTIVE, 1 LS, 2 SD, 3 WAKE.

Function
REQ-012 SHALL accept a command when cmd_valid and cmd_ready are both 1 in the same cycle.
REQ-013 SHALL select the bank with cmd_addr[log2(BANKS)-1:0] and the row with the remaining upper bits; BANKS=1 uses the full address as row.
REQ-014 SHALL enable only the selected bank in an accepted cycle; all other banks stay unselected.
REQ-015 SHALL on an accepted write update only bytes whose cmd_wem bit is 1 and produce no rsp_valid.
REQ-016 SHALL on an accepted read assert rsp_valid for exactly one cycle, one cycle after acceptance, with the addressed word on rsp_rdata.
REQ-017 SHALL hold rsp_rdata stable at the last read data until the next read response.
REQ-018 SHALL make a read following a write to the same address in the next cycle return the new data.
REQ-019 SHALL drive cmd_ready = 1 only in ACTIVE with no state transition pending in that cycle.
REQ-020 SHALL move ACTIVE->LS when pwr_ls_req=1, pwr_sd_req=0 and no read response is pending.
REQ-021 SHALL move ACTIVE->SD or LS->SD when pwr_sd_req=1 and no read response is pending; pwr_sd_req has priority over pwr_ls_req.
REQ-022 SHALL move LS->ACTIVE in one cycle when pwr_ls_req=0 or cmd_valid=1; a command waiting during LS is accepted in the first ACTIVE cycle.
REQ-023 SHALL move SD->WAKE when pwr_sd_req=0, then WAKE->ACTIVE after exactly WAKE_CYC cycles in WAKE.
REQ-024 SHALL preserve contents across LS; contents after SD are undefined.
REQ-025 SHALL ignore cmd_valid in LS (except as a wake trigger), SD and WAKE, and keep cmd_ready at 0 there.
REQ-026 SHALL in WAKE restart the wake counter from 0 if pwr_sd_req reasserts, returning to SD.

Reset
REQ-027 SHALL on assertion of rst_tcm immediately force pwr_state=ACTIVE, rsp_valid=0, rsp_rdata=0, wake counter=0 and cmd_ready=1 after release.
REQ-028 SHALL drop any in-flight read response when reset asserts mid-operation; memory contents are not reset.

Configuration
REQ-029 SHALL support the macro E203_TCM_RAM_OUTREG_EN.
REQ-030 SHALL, when E203_TCM_RAM_OUTREG_EN is defined, add one output register stage: read latency 2 cycles, back-to-back reads still return one response per cycle, and LS/SD entry waits for both stages to be empty.
REQ-031 SHALL, when E203_TCM_RAM_OUTREG_EN is undefined, use the 1-cycle read latency given in REQ-016.

Verification
REQ-032 SHALL cover: write addr 0x5 data 0xDEADBEEF wem 0xF, then read 0x5 -> rsp_valid one cycle after acceptance, rsp_rdata 0xDEADBEEF.
REQ-033 SHALL cover: write 0x11223344 to addr 0x2, then wem 0x2 with data 0x0000AA00 -> read returns 0x1122AA44.
REQ-034 SHALL cover: BANKS=2, back-to-back reads of 0x0 and 0x1 holding 0xA and 0xB -> consecutive rsp_valid cycles returning 0xA then 0xB; only bank 0 then bank 1 selected.
REQ-035 SHALL cover: pwr_ls_req=1 with cmd_valid=0 -> pwr_state=1 and cmd_ready=0; then cmd_valid=1 -> ACTIVE next cycle, command accepted, prior data intact.
REQ-036 SHALL cover: pwr_sd_req pulse with WAKE_CYC=4 -> SD, then WAKE for exactly 4 cycles, then ACTIVE with cmd_ready=1.
REQ-037 SHALL cover: rst_tcm asserted in the cycle after read acceptance -> no rsp_valid, rsp_rdata=0, pwr_state=0.
